adc_sequencer: RTL and testbench

Schedules all conversions and recalibrations of the single ADC front-end so that several datapath consumers (current/voltage monitors, protection logic) can share it. It arbitrates round-robin between requesters and drives the ADC `read`/`recalibrate` strobes. It captures `value` on the ADC's `read_done` and returns the sample to the granted requester. It inserts a recalibration after a programmable number of conversions and flags conversions that never complete.

---
 rtl/adc_sequencer_pkg.sv | 39 +++
 rtl/adc_sequencer_rr_arbiter.sv | 37 +++
 rtl/adc_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_adc_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sequencer_pkg.sv
// Shared state encoding, widths and per-clock-rate timing defaults for the ADC sequencer.
package adc_sequencer_pkg;

  localparam int ADC_W = 12;

  // Sample periods in clk cycles
  localparam int SAMPLE1K_CLK48  = 48_000;
  localparam int SAMPLE10K_CLK48 = 4_800;
  localparam int SAMPLE1K_CLK24  = 24_000;
  localparam int SAMPLE10K_CLK24 = 2_400;

  // 32 ADC calibration clocks plus margin, scaled to the system clock
  localparam int CAL_HOLD_CLK48 = 64;
  localparam int CAL_WAIT_CLK48 = 2048;
  localparam int TIMEOUT_CLK48  = 4096;
  localparam int CAL_HOLD_CLK24 = 32;
  localparam int CAL_WAIT_CLK24 = 1024;
  localparam int TIMEOUT_CLK24  = 2048;

  typedef enum logic [2:0] {
    ST_INIT_WAIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_READ      = 3'd2,
    ST_RESP      = 3'd3,
    ST_CAL_HOLD  = 3'd4,
    ST_CAL_WAIT  = 3'd5
  } state_t;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adc_sequencer_rr_arbiter.sv
// Round-robin pick of the first set request at or after ptr (wrapping); purely combinational.
// Zero latency; no backpressure, the caller decides when to take the grant.
module rr_arbiter
  import adc_sequencer_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int PTR_W = width_of(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_any
);

  // Two passes avoid a variable modulo index: upper slice from ptr first, then wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!gnt_any && req[j] && (j >= int'(ptr))) begin
        gnt_any = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!gnt_any && req[j] && (j < int'(ptr))) begin
        gnt_any = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Shares one ADC between N_REQ requesters: round-robin conversions, periodic/forced recalibration, timeout flag.
// adc_read_done rise to resp_valid is 4 cycles; req is a level held until its resp_valid, no other backpressure.
module adc_sequencer
  import adc_sequencer_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int RECAL_EVERY = 1024,
  parameter int CAL_HOLD    = CAL_HOLD_CLK48,
  parameter int CAL_WAIT    = CAL_WAIT_CLK48,
  parameter int TIMEOUT     = TIMEOUT_CLK48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             recal_req,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] resp_valid,
  output logic [ADC_W-1:0] resp_data,
  output logic             busy,
  output logic             timeout_err,
  output logic             adc_read,
  output logic             adc_recalibrate,
  input  logic             adc_read_done,
  input  logic [ADC_W-1:0] adc_value
);

  localparam int PTR_W = width_of(N_REQ);
  localparam int CNT_W = width_of(RECAL_EVERY + 1);
  localparam int TMR_W = width_of(max3(CAL_HOLD, CAL_WAIT, TIMEOUT));
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(RECAL_EVERY);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADC_W-1:0] data_q, data_d;
  logic [2:0]       sync_q, sync_d;
  logic             pend_q, pend_d;
  logic             terr_q, terr_d;
  logic             rd_q, rd_d;
  logic             cal_q, cal_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0] arb_idx;
  logic             arb_any;
  logic             done_rise;
  logic             recal_due;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the delayed copy for edge detect
  assign done_rise = sync_q[1] & ~sync_q[2];
  assign recal_due = pend_q | recal_req | ((RECAL_EVERY != 0) && (cnt_q == CNT_SAT));

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q + 1'b1;
    grant_d      = grant_q;
    resp_valid_d = '0;
    gidx_d       = gidx_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    sync_d       = {sync_q[1:0], adc_read_done};
    pend_d       = pend_q | recal_req;
    terr_d       = terr_q;
    rd_d         = 1'b0;
    cal_d        = 1'b0;

    unique case (state_q)
      ST_INIT_WAIT: begin
        if (tmr_q == TMR_W'(CAL_WAIT - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        tmr_d = '0;
        if (recal_due) begin
          state_d = ST_CAL_HOLD;
          cal_d   = 1'b1;
        end else if (arb_any) begin
          state_d = ST_READ;
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          rd_d    = 1'b1;
        end
      end
      ST_READ: begin
        if (done_rise) begin
          data_d  = adc_value;
          state_d = ST_RESP;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          // Request stays pending and is simply re-arbitrated from IDLE
          terr_d  = 1'b1;
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          rd_d = 1'b1;
        end
      end
      ST_RESP: begin
        resp_valid_d = grant_q;
        grant_d      = '0;
        rr_ptr_d     = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
        if ((RECAL_EVERY != 0) && (cnt_q != CNT_SAT)) begin
          cnt_d = cnt_q + 1'b1;
        end
        state_d = ST_IDLE;
      end
      ST_CAL_HOLD: begin
        if (tmr_q == TMR_W'(CAL_HOLD - 1)) begin
          tmr_d   = '0;
          state_d = ST_CAL_WAIT;
        end else begin
          cal_d = 1'b1;
        end
      end
      ST_CAL_WAIT: begin
        if (tmr_q == TMR_W'(CAL_WAIT - 1)) begin
          cnt_d   = '0;
          pend_d  = recal_req;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT_WAIT;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT_WAIT;
      tmr_q        <= '0;
      grant_q      <= '0;
      resp_valid_q <= '0;
      gidx_q       <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      sync_q       <= '0;
      pend_q       <= 1'b0;
      terr_q       <= 1'b0;
      rd_q         <= 1'b0;
      cal_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      grant_q      <= grant_d;
      resp_valid_q <= resp_valid_d;
      gidx_q       <= gidx_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      sync_q       <= sync_d;
      pend_q       <= pend_d;
      terr_q       <= terr_d;
      rd_q         <= rd_d;
      cal_q        <= cal_d;
    end
  end

  assign grant           = grant_q;
  assign resp_valid      = resp_valid_q;
  assign resp_data       = data_q;
  assign busy            = (state_q != ST_IDLE);
  assign timeout_err     = terr_q;
  assign adc_read        = rd_q;
  assign adc_recalibrate = cal_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: behavioural ADC with random latency/values and a round-robin reference model.
module tb_adc_sequencer;

  localparam int N_REQ       = 3;
  localparam int RECAL_EVERY = 4;
  localparam int CAL_HOLD    = 64;
  localparam int CAL_WAIT    = 2048;
  localparam int TIMEOUT     = 4096;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_REQ-1:0] req;
  logic             recal_req;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] resp_valid;
  logic [11:0]      resp_data;
  logic             busy;
  logic             timeout_err;
  logic             adc_read;
  logic             adc_recalibrate;
  logic             adc_read_done;
  logic [11:0]      adc_value;

  adc_sequencer #(
    .N_REQ(N_REQ), .RECAL_EVERY(RECAL_EVERY), .CAL_HOLD(CAL_HOLD),
    .CAL_WAIT(CAL_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .recal_req(recal_req),
    .grant(grant), .resp_valid(resp_valid), .resp_data(resp_data),
    .busy(busy), .timeout_err(timeout_err), .adc_read(adc_read),
    .adc_recalibrate(adc_recalibrate), .adc_read_done(adc_read_done),
    .adc_value(adc_value)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int ref_ptr    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model and strobe-edge recorder, evaluated on the falling edge
  logic [11:0] adc_vals[$];
  logic [11:0] last_val = '0;
  bit   adc_mute = 1'b0;
  int   adc_lat = 2, lat_cnt = 0;
  int   done_cyc = -1, rd_rise_cyc = -1, rd_fall_cyc = -1, cal_rise_cyc = -1, cal_fall_cyc = -1;
  logic prev_rd = 1'b0, prev_cal = 1'b0;

  initial begin
    adc_read_done = 1'b0;
    adc_value     = '0;
    forever begin
      @(negedge clk);
      if (adc_read && !prev_rd) rd_rise_cyc = cyc;
      if (!adc_read && prev_rd) rd_fall_cyc = cyc;
      if (adc_recalibrate && !prev_cal) cal_rise_cyc = cyc;
      if (!adc_recalibrate && prev_cal) cal_fall_cyc = cyc;
      prev_rd  = adc_read;
      prev_cal = adc_recalibrate;
      if (reset) begin
        adc_read_done = 1'b0;
        lat_cnt       = 0;
      end else if (adc_read_done) begin
        if (!adc_read) adc_read_done = 1'b0;
      end else if (adc_read && !adc_mute) begin
        if (lat_cnt >= adc_lat) begin
          if (adc_vals.size() > 0) last_val = adc_vals.pop_front();
          else last_val = 12'($urandom);
          adc_value     = last_val;
          adc_read_done = 1'b1;
          done_cyc      = cyc;
          lat_cnt       = 0;
          adc_lat       = $urandom_range(0, 5);
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N_REQ-1:0] r, input int p);
    logic [N_REQ-1:0] t;
    for (int k = 0; k < N_REQ; k++) begin
      t = r >> ((p + k) % N_REQ);
      if (t[0]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int i);
    return N_REQ'(1) << i;
  endfunction

  task automatic test_reset();
    int n, bad;
    reset = 1'b1; req = '0; recal_req = 1'b0;
    repeat (3) step();
    compared++; if (adc_read !== 1'b0) begin mismatched++; $display("FAIL rst_adc_read: got %b want 0", adc_read); end
    compared++; if (adc_recalibrate !== 1'b0) begin mismatched++; $display("FAIL rst_adc_recal: got %b want 0", adc_recalibrate); end
    compared++; if (grant !== '0) begin mismatched++; $display("FAIL rst_grant: got %b want 0", grant); end
    compared++; if (resp_valid !== '0) begin mismatched++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    compared++; if (resp_data !== '0) begin mismatched++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL rst_busy: got %b want 1", busy); end
    reset = 1'b0;
    n = 0; bad = 0;
    while (busy === 1'b1 && n < CAL_WAIT + 500) begin
      step(); n++;
      if (adc_read !== 1'b0 || adc_recalibrate !== 1'b0) bad++;
    end
    compared++; if (n != CAL_WAIT) begin mismatched++; $display("FAIL init_busy_len: got %0d want %0d", n, CAL_WAIT); end
    compared++; if (bad != 0) begin mismatched++; $display("FAIL init_strobes: got %0d active cycles want 0", bad); end
  endtask

  logic [11:0] rr_vals[4] = '{12'h111, 12'h222, 12'h333, 12'h111};
  int last_resp_cyc = -1;

  task automatic test_round_robin();
    int n, exp_idx, req_cyc;
    for (int k = 0; k < 4; k++) adc_vals.push_back(rr_vals[k]);
    req = 3'b111; req_cyc = cyc;
    for (int k = 0; k < 4; k++) begin
      exp_idx = rr_pick(req, ref_ptr);
      n = 0; while (adc_read !== 1'b1 && n < 100) begin step(); n++; end
      if (k == 0) begin
        compared++; if (rd_rise_cyc - req_cyc != 1) begin mismatched++; $display("FAIL req_to_read: got %0d cycles want 1", rd_rise_cyc - req_cyc); end
      end
      compared++; if (grant !== onehot(exp_idx)) begin mismatched++; $display("FAIL rr_grant[%0d]: got %b want %b", k, grant, onehot(exp_idx)); end
      n = 0; while (resp_valid === '0 && n < 100) begin step(); n++; end
      compared++; if (resp_valid !== onehot(exp_idx)) begin mismatched++; $display("FAIL rr_resp_valid[%0d]: got %b want %b", k, resp_valid, onehot(exp_idx)); end
      compared++; if (resp_data !== rr_vals[k]) begin mismatched++; $display("FAIL rr_resp_data[%0d]: got %h want %h", k, resp_data, rr_vals[k]); end
      compared++; if (cyc - done_cyc != 4) begin mismatched++; $display("FAIL rr_resp_latency[%0d]: got %0d want 4", k, cyc - done_cyc); end
      compared++; if (rd_fall_cyc - done_cyc < 1 || rd_fall_cyc - done_cyc > 3) begin mismatched++; $display("FAIL rr_read_fall[%0d]: got %0d want 1..3", k, rd_fall_cyc - done_cyc); end
      ref_ptr = (exp_idx + 1) % N_REQ;
      last_resp_cyc = cyc;
      step();
    end
  endtask

  task automatic test_auto_recal();
    int n, exp_idx;
    req = 3'b010;
    exp_idx = rr_pick(req, ref_ptr);
    compared++; if (cal_rise_cyc != last_resp_cyc + 1) begin mismatched++; $display("FAIL recal_start: got cyc %0d want %0d", cal_rise_cyc, last_resp_cyc + 1); end
    n = 0; while (adc_recalibrate === 1'b1 && n < CAL_HOLD + 50) begin step(); n++; end
    compared++; if (cal_fall_cyc - cal_rise_cyc != CAL_HOLD) begin mismatched++; $display("FAIL recal_hold: got %0d want %0d", cal_fall_cyc - cal_rise_cyc, CAL_HOLD); end
    n = 0; while (adc_read !== 1'b1 && n < CAL_WAIT + 100) begin step(); n++; end
    // CAL_WAIT cycles of settling, then one IDLE cycle to arbitrate the held request
    compared++; if (rd_rise_cyc - cal_fall_cyc != CAL_WAIT + 1) begin mismatched++; $display("FAIL recal_gap: got %0d want %0d", rd_rise_cyc - cal_fall_cyc, CAL_WAIT + 1); end
    compared++; if (grant !== onehot(exp_idx)) begin mismatched++; $display("FAIL recal_grant: got %b want %b", grant, onehot(exp_idx)); end
    n = 0; while (resp_valid === '0 && n < 100) begin step(); n++; end
    compared++; if (resp_valid !== onehot(exp_idx)) begin mismatched++; $display("FAIL recal_resp: got %b want %b", resp_valid, onehot(exp_idx)); end
    compared++; if (resp_data !== last_val) begin mismatched++; $display("FAIL recal_data: got %h want %h", resp_data, last_val); end
    ref_ptr = (exp_idx + 1) % N_REQ;
    req = '0;
  endtask

  task automatic test_timeout();
    int n, exp_idx, fall0;
    bit saw_resp;
    adc_mute = 1'b1;
    req = 3'b001;
    exp_idx = rr_pick(req, ref_ptr);
    n = 0; while (adc_read !== 1'b1 && n < 50) begin step(); n++; end
    compared++; if (grant !== onehot(exp_idx)) begin mismatched++; $display("FAIL to_grant: got %b want %b", grant, onehot(exp_idx)); end
    saw_resp = 1'b0;
    n = 0;
    while (adc_read === 1'b1 && n < TIMEOUT + 100) begin
      step(); n++;
      if (resp_valid !== '0) saw_resp = 1'b1;
    end
    compared++; if (rd_fall_cyc - rd_rise_cyc != TIMEOUT) begin mismatched++; $display("FAIL to_read_len: got %0d want %0d", rd_fall_cyc - rd_rise_cyc, TIMEOUT); end
    compared++; if (timeout_err !== 1'b1) begin mismatched++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
    compared++; if (grant !== '0) begin mismatched++; $display("FAIL to_grant_clear: got %b want 0", grant); end
    compared++; if (saw_resp) begin mismatched++; $display("FAIL to_no_resp: got resp_valid pulse want none"); end
    fall0 = rd_fall_cyc;
    n = 0; while (adc_read !== 1'b1 && n < 50) begin step(); n++; end
    compared++; if (rd_rise_cyc - fall0 != 1) begin mismatched++; $display("FAIL to_reissue: got %0d cycles want 1", rd_rise_cyc - fall0); end
    compared++; if (grant !== onehot(exp_idx)) begin mismatched++; $display("FAIL to_regrant: got %b want %b", grant, onehot(exp_idx)); end
    adc_mute = 1'b0;
    n = 0; while (resp_valid === '0 && n < 100) begin step(); n++; end
    compared++; if (resp_valid !== onehot(exp_idx)) begin mismatched++; $display("FAIL to_resp: got %b want %b", resp_valid, onehot(exp_idx)); end
    compared++; if (resp_data !== last_val) begin mismatched++; $display("FAIL to_data: got %h want %h", resp_data, last_val); end
    compared++; if (timeout_err !== 1'b1) begin mismatched++; $display("FAIL to_err_sticky: got %b want 1", timeout_err); end
    ref_ptr = (exp_idx + 1) % N_REQ;
    req = '0;
  endtask

  task automatic test_recal_req_during_read();
    int n, exp_idx, resp_cyc;
    bit saw_read;
    req = 3'b100;
    exp_idx = rr_pick(req, ref_ptr);
    n = 0; while (adc_read !== 1'b1 && n < 50) begin step(); n++; end
    compared++; if (grant !== onehot(exp_idx)) begin mismatched++; $display("FAIL rq_grant: got %b want %b", grant, onehot(exp_idx)); end
    recal_req = 1'b1; step(); recal_req = 1'b0;
    n = 0; while (resp_valid === '0 && n < 100) begin step(); n++; end
    compared++; if (resp_valid !== onehot(exp_idx)) begin mismatched++; $display("FAIL rq_resp: got %b want %b", resp_valid, onehot(exp_idx)); end
    compared++; if (resp_data !== last_val) begin mismatched++; $display("FAIL rq_data: got %h want %h", resp_data, last_val); end
    ref_ptr = (exp_idx + 1) % N_REQ;
    resp_cyc = cyc;
    exp_idx = rr_pick(req, ref_ptr);
    saw_read = 1'b0;
    n = 0;
    while (adc_recalibrate !== 1'b1 && n < 20) begin
      step(); n++;
      if (adc_read === 1'b1) saw_read = 1'b1;
    end
    compared++; if (cal_rise_cyc != resp_cyc + 1) begin mismatched++; $display("FAIL rq_cal_start: got cyc %0d want %0d", cal_rise_cyc, resp_cyc + 1); end
    compared++; if (saw_read) begin mismatched++; $display("FAIL rq_read_before_cal: got read want none"); end
    n = 0; while (adc_read !== 1'b1 && n < CAL_HOLD + CAL_WAIT + 100) begin step(); n++; end
    compared++; if (rd_rise_cyc - cal_rise_cyc != CAL_HOLD + CAL_WAIT + 1) begin mismatched++; $display("FAIL rq_next_read: got %0d want %0d", rd_rise_cyc - cal_rise_cyc, CAL_HOLD + CAL_WAIT + 1); end
    compared++; if (grant !== onehot(exp_idx)) begin mismatched++; $display("FAIL rq_regrant: got %b want %b", grant, onehot(exp_idx)); end
    n = 0; while (resp_valid === '0 && n < 100) begin step(); n++; end
    compared++; if (resp_valid !== onehot(exp_idx)) begin mismatched++; $display("FAIL rq_resp2: got %b want %b", resp_valid, onehot(exp_idx)); end
    ref_ptr = (exp_idx + 1) % N_REQ;
    req = '0;
  endtask

  task automatic test_async_reset();
    int n;
    adc_mute = 1'b1;
    req = 3'b001;
    n = 0; while (adc_read !== 1'b1 && n < 50) begin step(); n++; end
    step(); step();
    reset = 1'b1;
    #1;
    compared++; if (adc_read !== 1'b0) begin mismatched++; $display("FAIL ar_adc_read: got %b want 0", adc_read); end
    compared++; if (adc_recalibrate !== 1'b0) begin mismatched++; $display("FAIL ar_adc_recal: got %b want 0", adc_recalibrate); end
    compared++; if (grant !== '0) begin mismatched++; $display("FAIL ar_grant: got %b want 0", grant); end
    compared++; if (resp_valid !== '0) begin mismatched++; $display("FAIL ar_resp_valid: got %b want 0", resp_valid); end
    compared++; if (resp_data !== '0) begin mismatched++; $display("FAIL ar_resp_data: got %h want 0", resp_data); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL ar_timeout_err: got %b want 0", timeout_err); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL ar_busy: got %b want 1", busy); end
    adc_mute = 1'b0;
    req = '0;
    repeat (3) step();
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < CAL_WAIT + 500) begin step(); n++; end
    compared++; if (n != CAL_WAIT) begin mismatched++; $display("FAIL ar_init_len: got %0d want %0d", n, CAL_WAIT); end
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    recal_req = 1'b0;
    test_reset();
    test_round_robin();
    test_auto_recal();
    test_timeout();
    test_recal_req_during_read();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
